// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle between fetch_ctrl (master) and the PC register,
// instruction memory, hazard unit and branch/jump resolution (slave side).
interface fetch_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] pc_out;
    logic             imem_ready;
    logic             hazard_stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] pc_in;
    logic             stall_pc;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             ifid_write;
    logic             ifid_flush;
    logic             redirect_pending;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  pc_out, imem_ready, hazard_stall, branch_taken, branch_target,
               jump, jump_target,
        output pc_in, stall_pc, imem_req, imem_addr, ifid_write, ifid_flush,
               redirect_pending, stall_cnt
    );

    modport slave (
        output pc_out, imem_ready, hazard_stall, branch_taken, branch_target,
               jump, jump_target,
        input  pc_in, stall_pc, imem_req, imem_addr, ifid_write, ifid_flush,
               redirect_pending, stall_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: boot delay, imem handshake, next-PC selection,
// held redirects across in-flight fetches, IF/ID control and stall counting.
module fetch_ctrl #(
    parameter int WIDTH       = 32,
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

    typedef enum logic {BOOT, FETCH} state_e;

    localparam int               BCW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BCW-1:0]   BOOT_LAST  = BCW'(BOOT_CYCLES - 1);
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

    state_e           state_q, state_d;
    logic [BCW-1:0]   boot_cnt_q, boot_cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_branch_q, pend_branch_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             fetching;
    logic             redir;
    logic [WIDTH-1:0] redir_tgt;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] jmp_tgt;
    logic [WIDTH-1:0] pc_in_c;
    logic             stall_c;
    logic             write_c;
    logic             flush_c;

    assign br_tgt  = bus.branch_target & ALIGN_MASK;
    assign jmp_tgt = bus.jump_target & ALIGN_MASK;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // it unassigned; a missing default here would infer a latch.
        fetching      = rst && (state_q == FETCH);
        seq_pc        = bus.pc_out + WIDTH'(4);
        pc_in_c       = seq_pc;
        stall_c       = 1'b1;
        write_c       = 1'b0;
        flush_c       = 1'b0;
        redir         = 1'b0;
        redir_tgt     = seq_pc;
        pend_valid_d  = pend_valid_q;
        pend_branch_d = pend_branch_q;
        pend_tgt_d    = pend_tgt_q;
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        stall_cnt_d   = stall_cnt_q;

        if (fetching && bus.imem_ready) begin
            if (bus.branch_taken) begin
                redir     = 1'b1;
                redir_tgt = br_tgt;
            end else if (pend_valid_q) begin
                redir     = 1'b1;
                redir_tgt = pend_tgt_q;
            end else if (bus.jump) begin
                redir     = 1'b1;
                redir_tgt = jmp_tgt;
            end

            if (redir) begin
                pc_in_c       = redir_tgt;
                stall_c       = 1'b0;
                flush_c       = 1'b1;
                pend_valid_d  = 1'b0;
                pend_branch_d = 1'b0;
            end else if (!bus.hazard_stall) begin
                stall_c = 1'b0;
                write_c = 1'b1;
            end
        end else if (fetching) begin
            // A held branch is final; a held jump yields to a newer branch.
            if (bus.branch_taken && !(pend_valid_q && pend_branch_q)) begin
                pend_valid_d  = 1'b1;
                pend_branch_d = 1'b1;
                pend_tgt_d    = br_tgt;
            end else if (bus.jump && !pend_valid_q) begin
                pend_valid_d  = 1'b1;
                pend_branch_d = 1'b0;
                pend_tgt_d    = jmp_tgt;
            end
        end

        if (fetching && stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (state_q == BOOT) begin
            if (boot_cnt_q == BOOT_LAST) begin
                state_d = FETCH;
            end else begin
                boot_cnt_d = boot_cnt_q + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the values from before this edge, independent of block order.
        if (!rst) begin
            state_q       <= BOOT;
            boot_cnt_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_branch_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_branch_q <= pend_branch_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // NOTE: the pending target is left without reset; it is only ever read
    // while pend_valid_q is set, and that flag is reset.
    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
    end

    assign bus.pc_in            = pc_in_c;
    assign bus.stall_pc         = stall_c;
    assign bus.imem_req         = fetching;
    assign bus.imem_addr        = bus.pc_out;
    assign bus.ifid_write       = write_c;
    assign bus.ifid_flush       = flush_c;
    assign bus.redirect_pending = pend_valid_q;
    assign bus.stall_cnt        = stall_cnt_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller for the pipelined MIPS core. It sequences the program counter register by computing `pc_in` and `stall_pc` every cycle. It drives the instruction-memory request handshake and selects the next PC among sequential, jump and branch sources. It holds a redirect that arrives while a fetch is still in flight and writes or flushes the IF/ID register. It also counts fetch stall cycles for performance monitoring.

## Interface
- `WIDTH`, 32: PC/address width (matches `` `WIDTH ``).
- `BOOT_CYCLES`, 2: cycles after reset release before the first fetch request (≥1).
- `CNT_W`, 16: stall counter width.

- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `pc_out`  in  WIDTH  current PC from the PC register.
- `imem_ready`  in  1  instruction memory has completed the current request.
- `hazard_stall`  in  1  load-use stall from hazard unit.
- `branch_taken`  in  1  branch resolved taken (EX stage).
- `branch_target`  in  WIDTH  branch target.
- `jump`  in  1  jump decoded (ID stage).
- `jump_target`  in  WIDTH  jump target.
- `pc_in`  out  WIDTH  next PC to the PC register.
- `stall_pc`  out  1  hold the PC register.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  WIDTH  fetch address.
- `ifid_write`  out  1  capture fetched instruction into IF/ID.
- `ifid_flush`  out  1  clear IF/ID (one cycle per applied redirect).
- `redirect_pending`  out  1  a redirect is captured and waiting.
- `stall_cnt`  out  CNT_W  saturating count of fetch stall cycles.

## Operation
- States: BOOT, FETCH. Reset → BOOT with boot counter = 0. BOOT → FETCH when boot counter reaches BOOT_CYCLES-1. FETCH is held until reset.
- BOOT outputs: `imem_req`=0, `stall_pc`=1, `ifid_write`=0, `ifid_flush`=0.
- FETCH outputs: `imem_req`=1, `imem_addr`=`pc_out`. The address is held constant until `imem_ready`.
- FETCH with `imem_ready`=0:
  - `stall_pc`=1, `ifid_write`=0.
  - A redirect this cycle is captured into the pending register (valid, target).
- FETCH with `imem_ready`=1, priority highest first:
  1. New `branch_taken`: `pc_in`=`branch_target`.
  2. Pending redirect: `pc_in`=pending target.
  3. New `jump`: `pc_in`=`jump_target`.
  - Any of 1–3: `stall_pc`=0, `ifid_write`=0, `ifid_flush`=1, pending cleared.
  - Else `hazard_stall`=1: `stall_pc`=1, `ifid_write`=0. The same address is refetched next cycle.
  - Else: `pc_in`=`pc_out`+4 (modulo 2^WIDTH), `stall_pc`=0, `ifid_write`=1.
- Pending capture rules:
  - Branch and jump in the same cycle: branch captured.
  - A new branch overwrites a pending jump.
  - A pending branch is never overwritten.
  - A new jump is ignored while anything is pending.
- Redirect targets have bits [1:0] forced to 0.
- `redirect_pending` mirrors the pending valid flag.
- `stall_cnt` increments each FETCH cycle with `stall_pc`=1 and saturates at 2^CNT_W-1. It is not cleared except by reset.
- `pc_in` defaults to `pc_out`+4 whenever `stall_pc`=1.

## Timing
- `pc_in`, `stall_pc`, `imem_req`, `imem_addr`, `ifid_write`, `ifid_flush` are combinational from state and inputs. The PC register updates at the next edge.
- While `rst`=0, outputs are forced in the same cycle: `imem_req`=0, `stall_pc`=1, `ifid_write`=0, `ifid_flush`=0.
- At the reset edge: pending cleared, `redirect_pending`=0, `stall_cnt`=0, state = BOOT.
- Reset during an outstanding fetch abandons it. A late `imem_ready` is ignored whenever `imem_req`=0.
- Zero-wait memory (`imem_ready` tied 1): first request at cycle BOOT_CYCLES after reset release, then one instruction per cycle.
- Redirect latency:
  - Redirect arriving with `imem_ready`=1: target appears on `imem_addr` next cycle.
  - Redirect arriving earlier: target appears the cycle after the in-flight fetch completes.

## Test plan
- Reset release, `imem_ready`=1 → `stall_pc`=1 and `imem_req`=0 for 2 cycles, then `imem_addr` 0x0, 0x4, 0x8, 0xC on consecutive cycles with `ifid_write`=1.
- `imem_ready`=0 for 3 cycles at 0x8 → `imem_addr` held 0x8, `stall_pc`=1, `stall_cnt` +3; on ready `pc_in`=0xC.
- `branch_taken` to 0x40 while waiting at 0x10, ready 2 cycles later → `redirect_pending`=1. On ready: `ifid_write`=0, `ifid_flush`=1, `pc_in`=0x40. Next `imem_addr`=0x40.
- `branch_taken` 0x80 and `jump` 0x100 with ready=1 → `pc_in`=0x80. Pending jump 0x100, then branch 0x200 → `pc_in`=0x200 on ready.
- `hazard_stall`=1 with ready=1 at 0x14 → `stall_pc`=1, `ifid_write`=0, refetch 0x14. Same cycle plus `jump` 0x30 → `pc_in`=0x30, `ifid_flush`=1.
- `rst`=0 mid-wait with pending branch → `imem_req`=0 that cycle, then `redirect_pending`=0, `stall_cnt`=0, BOOT replayed.
